// File: rtl/prf_pkg.sv
// Shared types and sizing for the physical register file with ready bits.
// Every block of the slice imports this so tag and data widths agree.
package prf_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int PREG_WIDTH_DEF = 7;
  localparam int NUM_PREGS      = 2 ** PREG_WIDTH_DEF;
  localparam int NUM_RD_DEF     = 6;
  localparam int NUM_WR_DEF     = 3;

  typedef logic [DATA_WIDTH_DEF-1:0] data_t;
  typedef logic [PREG_WIDTH_DEF-1:0] preg_t;

endpackage

// File: rtl/prf_ready_file_if.sv
// Bundle of read, writeback, rename-alloc and flush signals for the
// physical register file. The master side drives tags, writes and control.
// The slave side (the register file) returns read data, ready bits and the
// conflict flag.
interface prf_ready_file_if
  import prf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PREG_WIDTH = PREG_WIDTH_DEF,
  parameter int NUM_RD     = NUM_RD_DEF,
  parameter int NUM_WR     = NUM_WR_DEF
);

  logic [PREG_WIDTH-1:0] rd_addr  [NUM_RD];
  logic [DATA_WIDTH-1:0] rd_data  [NUM_RD];
  logic [NUM_RD-1:0]     rd_ready;

  logic [NUM_WR-1:0]     wr_valid;
  logic [PREG_WIDTH-1:0] wr_dest  [NUM_WR];
  logic [DATA_WIDTH-1:0] wr_data  [NUM_WR];

  logic                  alloc_valid;
  logic [PREG_WIDTH-1:0] alloc_preg;
  logic                  flush;

  logic                  wr_conflict;

  modport master (
    output rd_addr, wr_valid, wr_dest, wr_data, alloc_valid, alloc_preg, flush,
    input  rd_data, rd_ready, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_valid, wr_dest, wr_data, alloc_valid, alloc_preg, flush,
    output rd_data, rd_ready, wr_conflict
  );

endinterface

// File: rtl/prf_bypass_mux.sv
// One read port's output selection: the stored register value, overridden by
// a same-cycle writeback to the same tag when forwarding is enabled. Tag 0 is
// hardwired to data 0 / ready 1 regardless of anything else.
module prf_bypass_mux
  import prf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PREG_WIDTH = PREG_WIDTH_DEF,
  parameter int NUM_WR     = NUM_WR_DEF,
  parameter int BYPASS     = 1
) (
  input  logic [PREG_WIDTH-1:0] rd_addr_i,
  input  logic [DATA_WIDTH-1:0] stored_data_i,
  input  logic                  stored_ready_i,
  input  logic [NUM_WR-1:0]     wr_valid_i,
  input  logic [PREG_WIDTH-1:0] wr_dest_i [NUM_WR],
  input  logic [DATA_WIDTH-1:0] wr_data_i [NUM_WR],
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_ready_o
);

  // Scan write ports lowest to highest so the highest matching port wins.
  always_comb begin
    rd_data_o  = stored_data_i;
    rd_ready_o = stored_ready_i;
    for (int w = 0; w < NUM_WR; w++) begin
      if ((BYPASS != 0) && wr_valid_i[w] && (wr_dest_i[w] == rd_addr_i)) begin
        rd_data_o  = wr_data_i[w];
        rd_ready_o = 1'b1;
      end
    end
    if (rd_addr_i == '0) begin
      rd_data_o  = '0;
      rd_ready_o = 1'b1;
    end
  end

endmodule

// File: rtl/prf_ready_file.sv
// Physical register file with a per-tag ready bit for an out-of-order core.
// Writebacks commit data and set ready one edge later. Rename allocation
// clears ready. Flush marks everything ready again. Tag 0 is a constant zero.
module prf_ready_file
  import prf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PREG_WIDTH = PREG_WIDTH_DEF,
  parameter int NUM_RD     = NUM_RD_DEF,
  parameter int NUM_WR     = NUM_WR_DEF,
  parameter int BYPASS     = 1
) (
  input  logic              clk,
  input  logic              reset,
  prf_ready_file_if.slave   bus
);

  localparam int NumPregs = 2 ** PREG_WIDTH;

  logic [DATA_WIDTH-1:0] regFile_q   [NumPregs];
  logic [DATA_WIDTH-1:0] regFile_d   [NumPregs];
  logic [NumPregs-1:0]   readyBits_q;
  logic [NumPregs-1:0]   readyBits_d;
  logic                  wrConflict_q;
  logic                  wrConflict_d;

  logic [PREG_WIDTH-1:0] wrDest   [NUM_WR];
  logic [DATA_WIDTH-1:0] wrData   [NUM_WR];

  // Local copies of the writeback arrays so they can feed every read-port mux.
  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wrDest[w] = bus.wr_dest[w];
      wrData[w] = bus.wr_data[w];
    end
  end

  // Flag any pair of valid writes aimed at the same nonzero tag this cycle.
  always_comb begin
    wrConflict_d = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (bus.wr_valid[i] && bus.wr_valid[j] &&
            (bus.wr_dest[i] == bus.wr_dest[j]) && (bus.wr_dest[i] != '0)) begin
          wrConflict_d = 1'b1;
        end
      end
    end
  end

  // Next state: flush sets all ready, writes commit (highest port last), and
  // a non-flushed alloc clears ready last so it beats a same-tag write.
  always_comb begin
    regFile_d   = regFile_q;
    readyBits_d = readyBits_q;
    if (bus.flush) begin
      readyBits_d = '1;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.wr_valid[w] && (bus.wr_dest[w] != '0)) begin
        regFile_d[bus.wr_dest[w]]   = bus.wr_data[w];
        readyBits_d[bus.wr_dest[w]] = 1'b1;
      end
    end
    if (bus.alloc_valid && !bus.flush && (bus.alloc_preg != '0)) begin
      readyBits_d[bus.alloc_preg] = 1'b0;
    end
  end

  // State registers; reset dominates every same-cycle update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NumPregs; p++) begin
        regFile_q[p] <= '0;
      end
      readyBits_q  <= '1;
      wrConflict_q <= 1'b0;
    end else begin
      regFile_q    <= regFile_d;
      readyBits_q  <= readyBits_d;
      wrConflict_q <= wrConflict_d;
    end
  end

  assign bus.wr_conflict = wrConflict_q;

  for (genvar r = 0; r < NUM_RD; r++) begin : gRead
    logic [DATA_WIDTH-1:0] storedData;
    logic                  storedReady;
    logic [DATA_WIDTH-1:0] muxData;
    logic                  muxReady;

    assign storedData  = regFile_q[bus.rd_addr[r]];
    assign storedReady = readyBits_q[bus.rd_addr[r]];

    prf_bypass_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .PREG_WIDTH (PREG_WIDTH),
      .NUM_WR     (NUM_WR),
      .BYPASS     (BYPASS)
    ) uMux (
      .rd_addr_i      (bus.rd_addr[r]),
      .stored_data_i  (storedData),
      .stored_ready_i (storedReady),
      .wr_valid_i     (bus.wr_valid),
      .wr_dest_i      (wrDest),
      .wr_data_i      (wrData),
      .rd_data_o      (muxData),
      .rd_ready_o     (muxReady)
    );

    assign bus.rd_data[r]  = muxData;
    assign bus.rd_ready[r] = muxReady;
  end

endmodule
